// File: rtl/fpu_pkg.sv
// Shared types for the round-robin FPU scheduler: op codes, FSM state names and the canonical qNaN.
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_SUB = 2'b00,
    OP_ADD = 2'b01,
    OP_MUL = 2'b10,
    OP_ABS = 2'b11
  } fpu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fpu_rr_scheduler_if.sv
// Bundle of the requester, response and fpu-side signals of fpu_rr_scheduler.
// Handshakes: a transfer happens in a cycle where valid and ready are both high; on the request
// side ready is a one-hot accept pulse from the scheduler, on the response side valid, id, data
// and err hold steady until the consumer raises ready.
interface fpu_rr_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int N_BIT = 32,
  parameter int ID_W  = $clog2(N_REQ)
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][N_BIT-1:0] req_a;
  logic [N_REQ-1:0][N_BIT-1:0] req_b;
  logic [N_REQ-1:0][1:0]       req_op;

  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [ID_W-1:0]             rsp_id;
  logic [N_BIT-1:0]            rsp_data;
  logic                        rsp_err;

  logic [N_BIT-1:0]            fpu_a;
  logic [N_BIT-1:0]            fpu_b;
  logic [1:0]                  fpu_op;
  logic                        fpu_start;
  logic [N_BIT-1:0]            fpu_out;
  logic                        fpu_done;

  // Environment side: requesters, response consumer and the fpu instance.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, fpu_out, fpu_done,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
    input  fpu_a, fpu_b, fpu_op, fpu_start
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, fpu_out, fpu_done,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
    output fpu_a, fpu_b, fpu_op, fpu_start
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping; all-zero when en is low.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx
);

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fpu_rr_scheduler.sv
// Round-robin scheduler sharing one fpu between N_REQ requesters, one op in flight at a time.
// Optional MUL watchdog enabled by defining FPU_SCHED_TIMEOUT_EN.
module fpu_rr_scheduler
  import fpu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LOG_BIT = 5,
  parameter int EXP_BIT = 8,
  parameter int N_BIT   = 1 << LOG_BIT,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int TMO_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  fpu_rr_scheduler_if.slave   bus,
  output logic [1:0]          o_dbg_state
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_RESP  = RESP;

  // Empty marker block: shows up in the elaborated hierarchy when the widths disagree.
  if (N_BIT != (1 << LOG_BIT) || EXP_BIT >= N_BIT) begin : g_width_mismatch
  end

  logic [1:0]       r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [N_BIT-1:0] r_a;
  logic [N_BIT-1:0] r_b;
  logic [N_BIT-1:0] r_data;
  fpu_op_e          r_op;

  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gnt_idx;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic             w_idle;
  logic             w_tmo_hit;

  assign w_idle    = (r_state == S_IDLE);
  assign w_ptr_nxt = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req     (bus.req_valid),
    .ptr     (r_ptr),
    .en      (w_idle),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

`ifdef FPU_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] r_tmo;
  logic             r_err;

  // Counter is zeroed in ISSUE so it reads 0 on the first WAIT cycle.
  assign w_tmo_hit = (r_state == S_WAIT) && !bus.fpu_done &&
                     (r_tmo == TMO_W'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_tmo <= '0;
      end else if (r_state == S_WAIT) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
      if (w_tmo_hit) begin
        r_err <= 1'b1;
      end else if (r_state == S_RESP && bus.rsp_ready) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.rsp_err = r_err;
`else
  assign w_tmo_hit   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_SUB;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_gnt) begin
            r_a     <= bus.req_a[w_gnt_idx];
            r_b     <= bus.req_b[w_gnt_idx];
            r_op    <= fpu_op_e'(bus.req_op[w_gnt_idx]);
            r_id    <= w_gnt_idx;
            r_ptr   <= w_ptr_nxt;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A MUL that completes in its launch cycle skips WAIT entirely.
          if (r_op != OP_MUL || bus.fpu_done) begin
            r_data  <= bus.fpu_out;
            r_state <= S_RESP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.fpu_done) begin
            r_data  <= bus.fpu_out;
            r_state <= S_RESP;
          end else if (w_tmo_hit) begin
            r_data  <= N_BIT'(FP32_QNAN);
            r_state <= S_RESP;
          end
        end
        default: begin
          if (bus.rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.req_ready = w_gnt;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_data  = r_data;
  assign bus.fpu_a     = r_a;
  assign bus.fpu_b     = r_b;
  assign bus.fpu_op    = r_op;
  assign bus.fpu_start = (r_state == S_ISSUE);
  assign o_dbg_state   = r_state;

endmodule
